return_address_stack: RTL and testbench

RETURN_ADDRESS_STACK -- requirements
Module: return_address_stack

---
 rtl/return_address_stack_pkg.sv | 20 ++
 rtl/return_address_stack_fifo.sv | 59 +++++
 rtl/return_address_stack.sv | 111 +++++++++++
 tb/tb_return_address_stack.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/return_address_stack_pkg.sv
// rtl/return_address_stack_pkg.sv - shared config defaults and checkpoint type for the return address stack
package return_address_stack_pkg;

  typedef struct packed {
    int ras_depth;
    int ckpt_depth;
  } cpu_config_t;

  localparam cpu_config_t DEFAULT_CONFIG = '{ras_depth: 8, ckpt_depth: 4};

  // Checkpoint fields are sized for the largest supported stack so one type serves every instance.
  localparam int RAS_MAX_DEPTH = 256;
  localparam int RAS_PTR_MAX_W = $clog2(RAS_MAX_DEPTH);

  typedef struct packed {
    logic [RAS_PTR_MAX_W-1:0] ptr;
    logic [RAS_PTR_MAX_W:0]   cnt;
  } ras_checkpoint_t;

endpackage

// File: rtl/return_address_stack_fifo.sv
// rtl/return_address_stack_fifo.sv - power-of-two FIFO with clear and registered occupancy flags
module return_address_stack_fifo #(
  parameter type DATA_TYPE  = logic,
  parameter int  FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clear,
  input  logic     push,
  input  logic     pop,
  input  DATA_TYPE data_in,
  output DATA_TYPE data_out,
  output logic     empty,
  output logic     full
);
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  DATA_TYPE mem [FIFO_DEPTH];
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push && !clear && ((count_q != CNT_FULL) || do_pop);
    rd_ptr_d = rd_ptr_q + IDX_W'(do_pop);
    wr_ptr_d = wr_ptr_q + IDX_W'(do_push);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push) mem[wr_ptr_q] <= data_in;
  end

  assign data_out = mem[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);

endmodule

// File: rtl/return_address_stack.sv
// rtl/return_address_stack.sv - speculative return address stack with checkpointed commit and flush recovery
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int RAS_DEPTH  = DEFAULT_CONFIG.ras_depth,
  parameter int CKPT_DEPTH = DEFAULT_CONFIG.ckpt_depth
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] new_addr,
  input  logic        branch_fetched,
  input  logic        branch_retired,
  input  logic        flush,
  output logic [31:0] addr,
  output logic        valid,
  output logic        ckpt_full
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [31:0] stack [RAS_DEPTH];
  logic [PTR_W-1:0] spec_ptr_q, spec_ptr_d, com_ptr_q, com_ptr_d, stack_waddr;
  logic [CNT_W-1:0] spec_cnt_q, spec_cnt_d, com_cnt_q, com_cnt_d;
  logic stack_we, ckpt_empty, retire_ok, unused_ckpt_bits;
  ras_checkpoint_t ckpt_in, ckpt_out;

  assign retire_ok = branch_retired && !ckpt_empty;

  always_comb begin
    spec_ptr_d  = spec_ptr_q;
    spec_cnt_d  = spec_cnt_q;
    stack_we    = 1'b0;
    stack_waddr = spec_ptr_q;
    com_ptr_d   = com_ptr_q;
    com_cnt_d   = com_cnt_q;

    if (push && pop) begin
      stack_we = 1'b1;
      if (spec_cnt_q == '0) spec_cnt_d = CNT_W'(1);
    end else if (push) begin
      stack_we    = 1'b1;
      stack_waddr = spec_ptr_q + PTR_W'(1);
      spec_ptr_d  = spec_ptr_q + PTR_W'(1);
      if (spec_cnt_q != CNT_MAX) spec_cnt_d = spec_cnt_q + CNT_W'(1);
    end else if (pop && (spec_cnt_q != '0)) begin
      spec_ptr_d = spec_ptr_q - PTR_W'(1);
      spec_cnt_d = spec_cnt_q - CNT_W'(1);
    end

    ckpt_in.ptr = RAS_PTR_MAX_W'(spec_ptr_d);
    ckpt_in.cnt = (RAS_PTR_MAX_W + 1)'(spec_cnt_d);

    if (retire_ok) begin
      com_ptr_d = ckpt_out.ptr[PTR_W-1:0];
      com_cnt_d = ckpt_out.cnt[CNT_W-1:0];
    end

    // Recovery lands on the committed state including any retire in this same cycle.
    if (flush) begin
      spec_ptr_d = com_ptr_d;
      spec_cnt_d = com_cnt_d;
      stack_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      spec_ptr_q <= '0;
      spec_cnt_q <= '0;
      com_ptr_q  <= '0;
      com_cnt_q  <= '0;
    end else begin
      spec_ptr_q <= spec_ptr_d;
      spec_cnt_q <= spec_cnt_d;
      com_ptr_q  <= com_ptr_d;
      com_cnt_q  <= com_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && stack_we) stack[stack_waddr] <= new_addr;
  end

  return_address_stack_fifo #(
    .DATA_TYPE  (ras_checkpoint_t),
    .FIFO_DEPTH (CKPT_DEPTH)
  ) u_ckpt_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push     (branch_fetched && !flush),
    .pop      (branch_retired),
    .data_in  (ckpt_in),
    .data_out (ckpt_out),
    .empty    (ckpt_empty),
    .full     (ckpt_full)
  );

  assign unused_ckpt_bits = ^ckpt_out;
  assign addr  = stack[spec_ptr_q];
  assign valid = (spec_cnt_q != '0);

  a_retire_nonempty: assert property (@(posedge clk) disable iff (!rst)
    branch_retired |-> !ckpt_empty);
  a_fetch_not_dropped: assert property (@(posedge clk) disable iff (!rst)
    (branch_fetched && ckpt_full && !flush) |-> branch_retired);

endmodule

// File: tb/tb_return_address_stack.sv
// tb/tb_return_address_stack.sv - directed vector table plus randomized model comparison for return_address_stack
module tb_return_address_stack;
  localparam int RAS_DEPTH  = 8;
  localparam int CKPT_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push = 1'b0, pop = 1'b0, branch_fetched = 1'b0, branch_retired = 1'b0, flush = 1'b0;
  logic [31:0] new_addr = '0;
  logic [31:0] addr;
  logic        valid, ckpt_full;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  return_address_stack #(.RAS_DEPTH(RAS_DEPTH), .CKPT_DEPTH(CKPT_DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .new_addr(new_addr),
    .branch_fetched(branch_fetched), .branch_retired(branch_retired), .flush(flush),
    .addr(addr), .valid(valid), .ckpt_full(ckpt_full)
  );

  typedef struct {
    logic        r, p, o, f, b, l;
    logic [31:0] a;
    logic        ev;
    logic [31:0] ea;
    logic        ef;
    int          ec;
  } vec_t;
  vec_t vecs[$];

  // Reference: circular array of return addresses, a top index and a live count, plus a queue of checkpoints.
  typedef struct { int top; int cnt; } ck_t;
  logic [31:0] m_mem [RAS_DEPTH];
  int m_top = 0, m_cnt = 0, m_ctop = 0, m_ccnt = 0;
  ck_t m_ck[$];

  function automatic void add(logic r, logic p, logic o, logic [31:0] a, logic f, logic b, logic l,
                              logic ev, logic [31:0] ea, logic ef, int ec);
    vec_t v;
    v.r = r; v.p = p; v.o = o; v.a = a; v.f = f; v.b = b; v.l = l;
    v.ev = ev; v.ea = ea; v.ef = ef; v.ec = ec;
    vecs.push_back(v);
  endfunction

  function automatic void model_step();
    ck_t c;
    if (!rst) begin
      m_top = 0; m_cnt = 0; m_ctop = 0; m_ccnt = 0;
      m_ck.delete();
      return;
    end
    if (branch_retired && m_ck.size() > 0) begin
      c = m_ck.pop_front();
      m_ctop = c.top; m_ccnt = c.cnt;
    end
    if (flush) begin
      m_top = m_ctop; m_cnt = m_ccnt;
      m_ck.delete();
      return;
    end
    if (push && pop) begin
      m_mem[m_top] = new_addr;
      if (m_cnt == 0) m_cnt = 1;
    end else if (push) begin
      m_top = (m_top + 1) % RAS_DEPTH;
      m_mem[m_top] = new_addr;
      if (m_cnt < RAS_DEPTH) m_cnt++;
    end else if (pop && m_cnt > 0) begin
      m_top = (m_top + RAS_DEPTH - 1) % RAS_DEPTH;
      m_cnt--;
    end
    if (branch_fetched && m_ck.size() < CKPT_DEPTH) begin
      c.top = m_top; c.cnt = m_cnt;
      m_ck.push_back(c);
    end
  endfunction

  task automatic apply(logic r, logic p, logic o, logic [31:0] a, logic f, logic b, logic l);
    rst = r; push = p; pop = o; new_addr = a; branch_fetched = f; branch_retired = b; flush = l;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    logic r, p, o, f, b, l;
    logic [31:0] a;

    // reset, basic LIFO and underflow
    add(0,0,0,'h000,0,0,0, 0,'h000,0,0);
    add(1,1,0,'h100,0,0,0, 1,'h100,0,1);
    add(1,1,0,'h200,0,0,0, 1,'h200,0,2);
    add(1,1,0,'h300,0,0,0, 1,'h300,0,3);
    add(1,0,1,'h000,0,0,0, 1,'h200,0,2);
    add(1,0,1,'h000,0,0,0, 1,'h100,0,1);
    add(1,0,1,'h000,0,0,0, 0,'h000,0,0);
    add(1,0,1,'h000,0,0,0, 0,'h000,0,0);
    add(1,1,0,'h111,0,0,0, 1,'h111,0,1);
    add(1,0,1,'h000,0,0,0, 0,'h000,0,0);
    // push+pop replaces the top; on an empty stack it creates one entry
    add(1,1,0,'h040,0,0,0, 1,'h040,0,1);
    add(1,1,1,'h080,0,0,0, 1,'h080,0,1);
    add(1,0,1,'h000,0,0,0, 0,'h000,0,0);
    add(1,1,1,'h077,0,0,0, 1,'h077,0,1);
    add(1,0,1,'h000,0,0,0, 0,'h000,0,0);
    // checkpoint, retire, flush back to committed state
    add(0,0,0,'h000,0,0,0, 0,'h000,0,0);
    add(1,1,0,'h0A0,1,0,0, 1,'h0A0,0,1);
    add(1,0,0,'h000,0,1,0, 1,'h0A0,0,1);
    add(1,1,0,'h0B0,1,0,0, 1,'h0B0,0,2);
    add(1,0,0,'h000,0,0,1, 1,'h0A0,0,1);
    add(1,0,1,'h000,0,0,0, 0,'h000,0,0);
    // checkpoint FIFO fill, full with simultaneous retire, drain
    add(0,0,0,'h000,0,0,0, 0,'h000,0,0);
    add(1,0,0,'h000,1,0,0, 0,'h000,0,0);
    add(1,0,0,'h000,1,0,0, 0,'h000,0,0);
    add(1,0,0,'h000,1,0,0, 0,'h000,0,0);
    add(1,0,0,'h000,1,0,0, 0,'h000,1,0);
    add(1,0,0,'h000,1,1,0, 0,'h000,1,0);
    add(1,0,0,'h000,0,1,0, 0,'h000,0,0);
    add(1,0,0,'h000,0,1,0, 0,'h000,0,0);
    add(1,0,0,'h000,0,1,0, 0,'h000,0,0);
    add(1,0,0,'h000,0,1,0, 0,'h000,0,0);
    // reset in the middle of activity
    add(0,0,0,'h000,0,0,0, 0,'h000,0,0);
    add(1,1,0,'h011,1,0,0, 1,'h011,0,1);
    add(1,1,0,'h022,1,0,0, 1,'h022,0,2);
    add(1,1,0,'h033,1,0,0, 1,'h033,0,3);
    add(1,0,0,'h000,1,0,0, 1,'h033,1,3);
    add(0,1,0,'h055,1,0,0, 0,'h000,0,0);
    add(1,1,0,'h066,0,0,0, 1,'h066,0,1);

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].p, vecs[i].o, vecs[i].a, vecs[i].f, vecs[i].b, vecs[i].l);
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].ev));
      if (vecs[i].ev) check($sformatf("vec%0d_addr", i), addr, vecs[i].ea);
      check($sformatf("vec%0d_ckpt_full", i), 32'(ckpt_full), 32'(vecs[i].ef));
      check($sformatf("vec%0d_count", i), 32'(dut.spec_cnt_q), 32'(vecs[i].ec));
    end

    // overflow: nine pushes into eight entries keep the newest eight
    apply(0,0,0,0,0,0,0);
    for (int i = 1; i <= 9; i++) apply(1,1,0,32'(i * 'h10),0,0,0);
    check("ovf_count", 32'(dut.spec_cnt_q), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ovf_pop%0d_addr", k), addr, 32'('h90 - k * 'h10));
      apply(1,0,1,0,0,0,0);
    end
    check("ovf_empty_valid", 32'(valid), 32'd0);

    // randomized traffic against the reference
    apply(0,0,0,0,0,0,0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) != 0);
      p = ($urandom_range(0, 9) < 4);
      o = ($urandom_range(0, 9) < 4);
      a = $urandom;
      l = ($urandom_range(0, 19) == 0);
      b = (m_ck.size() > 0) && ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 2) == 0) && ((m_ck.size() < CKPT_DEPTH) || b);
      apply(r, p, o, a, f, b, l);
      check("rnd_valid", 32'(valid), 32'(m_cnt != 0));
      if (m_cnt != 0) check("rnd_addr", addr, m_mem[m_top]);
      check("rnd_ckpt_full", 32'(ckpt_full), 32'(m_ck.size() == CKPT_DEPTH));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
